// File: rtl/sdp_ram_be.sv
// Single-clock simple dual-port RAM with byte-lane writes and a 1- or 2-stage read path.
// Define SDP_RAM_BYPASS_EN to merge same-cycle write lanes into a colliding read (default: read-first).
module sdp_ram_be #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 16,
  parameter int BWIDTH = 8,
  parameter int RDLAT  = 1
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       wen,
  input  logic [AWIDTH-1:0]          waddr,
  input  logic [DWIDTH/BWIDTH-1:0]   wbe,
  input  logic [DWIDTH-1:0]          wdata,
  input  logic                       ren,
  input  logic [AWIDTH-1:0]          raddr,
  output logic                       rdv,
  output logic [DWIDTH-1:0]          rdata,
  output logic                       rcoll
);
  localparam int NLANE = DWIDTH / BWIDTH;

  generate
    if (DWIDTH % BWIDTH != 0) begin : g_bad_width
      $error("sdp_ram_be: DWIDTH must be a multiple of BWIDTH");
    end
    if (RDLAT != 1 && RDLAT != 2) begin : g_bad_lat
      $error("sdp_ram_be: RDLAT must be 1 or 2");
    end
  endgenerate

  // Array is intentionally not reset so contents survive arst.
  logic [DWIDTH-1:0] mem [0:2**AWIDTH-1];

  always_ff @(posedge clk) begin
    if (wen && !arst) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wbe[i]) mem[waddr][i*BWIDTH +: BWIDTH] <= wdata[i*BWIDTH +: BWIDTH];
      end
    end
  end

  logic [DWIDTH-1:0] old_word;
  logic [DWIDTH-1:0] rd_word;
  logic              coll;

  assign old_word = mem[raddr];
  assign coll     = wen && (wbe != '0) && (raddr == waddr);

`ifdef SDP_RAM_BYPASS_EN
  always_comb begin
    rd_word = old_word;
    for (int i = 0; i < NLANE; i++) begin
      if (coll && wbe[i]) rd_word[i*BWIDTH +: BWIDTH] = wdata[i*BWIDTH +: BWIDTH];
    end
  end
`else
  assign rd_word = old_word;
`endif

  generate
    if (RDLAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          rdv   <= 1'b0;
          rdata <= '0;
          rcoll <= 1'b0;
        end else begin
          rdv   <= ren;
          rcoll <= ren & coll;
          if (ren) rdata <= rd_word;
        end
      end
    end else begin : g_lat2
      logic              s1_v;
      logic              s1_c;
      logic [DWIDTH-1:0] s1_d;

      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          s1_v  <= 1'b0;
          s1_c  <= 1'b0;
          s1_d  <= '0;
          rdv   <= 1'b0;
          rdata <= '0;
          rcoll <= 1'b0;
        end else begin
          s1_v  <= ren;
          s1_c  <= ren & coll;
          if (ren) s1_d <= rd_word;
          rdv   <= s1_v;
          rcoll <= s1_v & s1_c;
          if (s1_v) rdata <= s1_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Scoreboard bench for sdp_ram_be: one RDLAT=1 and one RDLAT=2 instance share the same stimulus.
// Expected collision data follows SDP_RAM_BYPASS_EN.
module tb_sdp_ram_be;
  logic        clk = 1'b0;
  logic        arst;
  logic        wen;
  logic [8:0]  waddr;
  logic [1:0]  wbe;
  logic [15:0] wdata;
  logic        ren;
  logic [8:0]  raddr;
  logic        rdv1, rcoll1, rdv2, rcoll2;
  logic [15:0] rdata1, rdata2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          at;
    logic [15:0] d;
    logic        chk;
    logic        c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  sdp_ram_be #(.AWIDTH(9), .DWIDTH(16), .BWIDTH(8), .RDLAT(1)) u1 (
    .clk(clk), .arst(arst), .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdv(rdv1), .rdata(rdata1), .rcoll(rcoll1));

  sdp_ram_be #(.AWIDTH(9), .DWIDTH(16), .BWIDTH(8), .RDLAT(2)) u2 (
    .clk(clk), .arst(arst), .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdv(rdv2), .rdata(rdata2), .rcoll(rcoll2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rdv pulse, checking arrival cycle, data and rcoll.
  always @(negedge clk) begin
    exp_t e;
    if (rdv1) begin
      if (q1.size() == 0) check("lat1 unexpected rdv", 1, 0);
      else begin
        e = q1.pop_front();
        check("lat1 rdv cycle", cyc, e.at);
        if (e.chk) check("lat1 rdata", {16'h0, rdata1}, {16'h0, e.d});
        check("lat1 rcoll", {31'h0, rcoll1}, {31'h0, e.c});
      end
    end else if (rcoll1) check("lat1 rcoll without rdv", 1, 0);
    if (rdv2) begin
      if (q2.size() == 0) check("lat2 unexpected rdv", 1, 0);
      else begin
        e = q2.pop_front();
        check("lat2 rdv cycle", cyc, e.at);
        if (e.chk) check("lat2 rdata", {16'h0, rdata2}, {16'h0, e.d});
        check("lat2 rcoll", {31'h0, rcoll2}, {31'h0, e.c});
      end
    end else if (rcoll2) check("lat2 rcoll without rdv", 1, 0);
  end

  // One clock of stimulus; a read pushes its expectation for both instances when not in reset.
  task automatic op(input logic dw, input logic [8:0] wa, input logic [1:0] be, input logic [15:0] wd,
                    input logic dr, input logic [8:0] ra, input logic [15:0] ed, input logic ec);
    exp_t e;
    wen = dw; waddr = wa; wbe = be; wdata = wd;
    ren = dr; raddr = ra;
    if (dr && !arst) begin
      e.d = ed; e.chk = 1'b1; e.c = ec;
      e.at = cyc + 1; q1.push_back(e);
      e.at = cyc + 2; q2.push_back(e);
    end
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " rdv1"},   {31'h0, rdv1},   0);
    check({tag, " rdata1"}, {16'h0, rdata1}, 0);
    check({tag, " rcoll1"}, {31'h0, rcoll1}, 0);
    check({tag, " rdv2"},   {31'h0, rdv2},   0);
    check({tag, " rdata2"}, {16'h0, rdata2}, 0);
    check({tag, " rcoll2"}, {31'h0, rcoll2}, 0);
  endtask

  task automatic assert_reset();
    arst = 1'b1;
    q1.delete();
    q2.delete();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [15:0] coll_d;
`ifdef SDP_RAM_BYPASS_EN
    coll_d = 16'hBECD;
`else
    coll_d = 16'h12CD;
`endif
    arst = 1'b1; wen = 0; waddr = 0; wbe = 0; wdata = 0; ren = 0; raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("power-on");
    arst = 1'b0;

    // Pre-reset content, then reset with writes/reads toggling.
    op(1, 9'd7, 2'b11, 16'h5A5A, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9'd7, 16'h5A5A, 0);
    idle(2);
    @(posedge clk); #2;
    assert_reset();
    check_reset_outs("reset asserted");
    for (int i = 0; i < 4; i++) begin
      op(i[0], 9'd7, 2'b11, 16'hFFFF, ~i[0], 9'd7, 0, 0);
      check_reset_outs("reset held");
    end
    arst = 1'b0;
    op(0, 0, 0, 0, 1, 9'd7, 16'h5A5A, 0);
    idle(2);

    // Full write, partial write, collisions.
    op(1, 9'd5, 2'b11, 16'h1234, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9'd5, 16'h1234, 0);
    idle(2);
    op(1, 9'd5, 2'b01, 16'hABCD, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9'd5, 16'h12CD, 0);
    idle(2);
    op(1, 9'd5, 2'b10, 16'hBEEF, 1, 9'd5, coll_d, 1);
    op(0, 0, 0, 0, 1, 9'd5, 16'hBECD, 0);
    op(1, 9'd5, 2'b00, 16'h0000, 1, 9'd5, 16'hBECD, 0);
    op(1, 9'd6, 2'b11, 16'h6666, 1, 9'd5, 16'hBECD, 0);
    op(0, 0, 0, 0, 1, 9'd6, 16'h6666, 0);
    op(1, 9'd511, 2'b11, 16'h0F0F, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9'd511, 16'h0F0F, 0);
    idle(3);

    // Back-to-back reads; a write on the edge after a read must not alter it.
    op(1, 9'd1, 2'b11, 16'h0011, 0, 0, 0, 0);
    op(1, 9'd2, 2'b11, 16'h0022, 0, 0, 0, 0);
    op(1, 9'd3, 2'b11, 16'h0033, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9'd1, 16'h0011, 0);
    op(0, 0, 0, 0, 1, 9'd2, 16'h0022, 0);
    op(0, 0, 0, 0, 1, 9'd3, 16'h0033, 0);
    op(1, 9'd3, 2'b11, 16'h7777, 1, 9'd2, 16'h0022, 0);
    op(0, 0, 0, 0, 1, 9'd3, 16'h7777, 0);
    idle(3);

    // Reset while a read is in flight.
    op(0, 0, 0, 0, 1, 9'd1, 16'h0011, 0);
    #1;
    assert_reset();
    check_reset_outs("midflight reset");
    idle(3);
    check_reset_outs("midflight held");
    arst = 1'b0;
    op(0, 0, 0, 0, 1, 9'd1, 16'h0011, 0);
    idle(4);

    check("lat1 queue drained", q1.size(), 0);
    check("lat2 queue drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdp_ram_be.md
# sdp_ram_be

Single-clock simple dual-port RAM with per-lane byte-enable writes, a selectable 1- or 2-stage registered read path, and an optional same-cycle write-to-read bypass. It is the next-generation buffer primitive for single-clock FIFOs, line buffers and packet stores that do not need a clock crossing. One write port and one read port operate on every clock edge independently.

## Interface
- AWIDTH, 9, address width; depth is 2**AWIDTH words.
- DWIDTH, 16, word width in bits; must be an integer multiple of BWIDTH.
- BWIDTH, 8, byte-lane width in bits; NLANE = DWIDTH/BWIDTH.
- RDLAT, 1, read latency in clocks; legal values are 1 and 2.

- clk  in  1  single clock for both ports; all state updates on posedge.
- arst  in  1  asynchronous, active-high reset.
- wen  in  1  write request; samples waddr, wbe and wdata.
- waddr  in  AWIDTH  write word address.
- wbe  in  NLANE  byte-lane write enables; bit i covers wdata[i*BWIDTH +: BWIDTH].
- wdata  in  DWIDTH  write data.
- ren  in  1  read request; samples raddr.
- raddr  in  AWIDTH  read word address.
- rdv  out  1  read data valid; high for exactly one clock per accepted read.
- rdata  out  DWIDTH  read data.
- rcoll  out  1  high with rdv when the read collided with a same-cycle write to the same address.

## Operation
- Write: at a posedge with wen=1 and arst=0, each lane i with wbe[i]=1 is written at waddr. Lanes with wbe[i]=0 keep their old value. wen=1 with wbe=0 is a no-op.
- Read: a posedge with ren=1 and arst=0 accepts a read of raddr. Exactly one rdv pulse follows RDLAT edges later. Reads are accepted every cycle, so there is no backpressure.
- Read path:
  - RDLAT=1: rdata loads from the array on the accepting edge.
  - RDLAT=2: a stage-1 data/valid register loads on the accepting edge; stage 2 (rdata/rdv) loads from stage 1 on the next edge.
- rdata holds its last value whenever no new read completes. rdv is low in those cycles.
- Collision: ren=1, wen=1 and raddr==waddr on the same edge.
  - Default behaviour is read-first: the old word is returned.
  - The bypass case is defined under Configuration.
  - rcoll is pipelined with rdv and is 0 whenever rdv is 0.
- Only a write on the read's accepting edge is considered a collision. With RDLAT=2, a write on the following edge does not alter data already captured in stage 1.
- The memory array is not reset. Reading a never-written word returns X, and the bench treats that as don't-care.
- Parameter checks:
  - DWIDTH % BWIDTH != 0 is an elaboration error.
  - RDLAT not in {1,2} is an elaboration error.

## Timing
- Reset values: rdv=0, rdata=0, rcoll=0. Stage-1 valid, data and collision registers are also 0.
- arst assertion clears the above asynchronously, without waiting for clk. Reads still in flight are dropped and never produce rdv.
- While arst=1, wen and ren are ignored. Array contents written before reset are preserved.
- The first accepted read is on the first posedge at which arst=0.
- Latency from ren to rdv/rdata is RDLAT clocks. Throughput is one read and one write per clock.
- Back-to-back reads give back-to-back rdv pulses, with data in request order.
- A write on edge N is visible to a read accepted on edge N+1 or later in all configurations.

## Configuration
- SDP_RAM_BYPASS_EN defined: on a collision, the read returns a merged word.
  - Lane i takes wdata lane i if wbe[i]=1; otherwise it takes the old array lane.
  - rcoll=1 with the matching rdv when any wbe bit was set.
  - Mux depth is one comparator plus one 2:1 mux per lane ahead of the first read register.
- SDP_RAM_BYPASS_EN undefined: collisions are read-first and return the old word. rcoll still flags a collision (wen=1, wbe!=0, same address). No bypass mux is built.

## Test plan
- Reset: hold arst=1 with ren=1 and wen=1 toggling -> rdv=0, rdata=0x0000 and rcoll=0 throughout. After release, a read of a location written pre-reset returns the pre-reset data.
- Full write/read (RDLAT=1): write 0x1234 to address 5 with wbe=2'b11. Read address 5 on the next cycle -> rdv=1 and rdata=0x1234 one clock after ren; rdv=0 the clock after that.
- Partial write: after the previous step, write 0xABCD to address 5 with wbe=2'b01. Read address 5 -> 0x12CD.
- Collision: read address 5 while writing 0xBEEF there with wbe=2'b10 on the same edge.
  - With the macro -> rdata=0xBECD, rcoll=1.
  - Without the macro -> rdata=0x12CD, rcoll=1.
  - In both cases the next read of address 5 -> 0xBECD, rcoll=0.
- Pipelining (RDLAT=2): preload addresses 1, 2, 3 with 0x0011, 0x0022, 0x0033. Issue ren on three consecutive edges -> rdv is high for three consecutive clocks starting 2 clocks after the first ren, with rdata 0x0011, 0x0022, 0x0033.
- Reset mid-flight (RDLAT=2): issue ren on edge N and assert arst between edges N and N+2 -> rdv never rises and rdata=0 immediately on assertion. After release, re-reading returns the stored word.
